// File: rtl/calc_sequencer_if.sv
// Keypad-event, ALU-handshake and display-control bundle of the calculator sequencer.
interface calc_sequencer_if;
    logic       key_valid;
    logic [3:0] key_value;
    logic       alu_done;
    logic       alu_err;

    logic       digit_shift;
    logic [3:0] key_digit;
    logic       clr_entry;
    logic       load_a;
    logic       load_a_res;
    logic       load_b;
    logic       alu_start;
    logic [1:0] op;
    logic [1:0] disp_sel;
    logic [2:0] digit_cnt;
    logic [2:0] state;

    // Environment side: keypad scanner, arithmetic unit and display.
    modport master (
        output key_valid, key_value, alu_done, alu_err,
        input  digit_shift, key_digit, clr_entry, load_a, load_a_res,
               load_b, alu_start, op, disp_sel, digit_cnt, state
    );

    // Sequencer side.
    modport slave (
        input  key_valid, key_value, alu_done, alu_err,
        output digit_shift, key_digit, clr_entry, load_a, load_a_res,
               load_b, alu_start, op, disp_sel, digit_cnt, state
    );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator input sequencer: turns key events into operand-entry, ALU-start and
// display-select controls for the flow A, operator, B, '=', result.
module calc_sequencer #(
    parameter int MAX_DIGITS = 3,
    parameter int TIMEOUT    = 255
) (
    input logic             clk,
    input logic             reset,
    calc_sequencer_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER_A = 3'd1,
        ENTER_B = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4,
        ERROR   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [3:0]      digit_q, digit_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            key_prev;

    logic            shift_q, shift_d;
    logic            clr_q, clr_d;
    logic            lda_q, lda_d;
    logic            ldar_q, ldar_d;
    logic            ldb_q, ldb_d;
    logic            start_q, start_d;

    logic            press;
    logic            is_digit, is_op, is_clr, is_eq;
    logic            room;
    logic [1:0]      op_code;

    assign press    = bus.key_valid & ~key_prev;
    assign is_digit = (bus.key_value <= 4'd9);
    assign is_op    = (bus.key_value >= 4'hA) && (bus.key_value <= 4'hD);
    assign is_clr   = (bus.key_value == 4'hE);
    assign is_eq    = (bus.key_value == 4'hF);
    assign op_code  = 2'(bus.key_value - 4'd10);
    assign room     = (cnt_q < 3'(MAX_DIGITS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            digit_q  <= '0;
            tcnt_q   <= '0;
            key_prev <= 1'b0;
            shift_q  <= 1'b0;
            clr_q    <= 1'b0;
            lda_q    <= 1'b0;
            ldar_q   <= 1'b0;
            ldb_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            tcnt_q   <= tcnt_d;
            key_prev <= bus.key_valid;
            shift_q  <= shift_d;
            clr_q    <= clr_d;
            lda_q    <= lda_d;
            ldar_q   <= ldar_d;
            ldb_q    <= ldb_d;
            start_q  <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        tcnt_d  = tcnt_q;
        shift_d = 1'b0;
        clr_d   = 1'b0;
        lda_d   = 1'b0;
        ldar_d  = 1'b0;
        ldb_d   = 1'b0;
        start_d = 1'b0;

        // Clear overrides everything, including a completion arriving in EXEC.
        if (press && is_clr) begin
            clr_d   = 1'b1;
            cnt_d   = '0;
            op_d    = '0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (press && is_digit) begin
                        shift_d = 1'b1;
                        digit_d = bus.key_value;
                        cnt_d   = 3'd1;
                        state_d = ENTER_A;
                    end
                end

                ENTER_A: begin
                    if (press && is_digit && room) begin
                        shift_d = 1'b1;
                        digit_d = bus.key_value;
                        cnt_d   = cnt_q + 3'd1;
                    end else if (press && is_op) begin
                        lda_d   = 1'b1;
                        clr_d   = 1'b1;
                        op_d    = op_code;
                        cnt_d   = '0;
                        state_d = ENTER_B;
                    end
                end

                ENTER_B: begin
                    if (press && is_digit && room) begin
                        shift_d = 1'b1;
                        digit_d = bus.key_value;
                        cnt_d   = cnt_q + 3'd1;
                    end else if (press && is_op && cnt_q == 3'd0) begin
                        op_d = op_code;
                    end else if (press && is_eq && cnt_q != 3'd0) begin
                        ldb_d   = 1'b1;
                        start_d = 1'b1;
                        tcnt_d  = '0;
                        state_d = EXEC;
                    end
                end

                EXEC: begin
                    if (bus.alu_done) begin
                        state_d = bus.alu_err ? ERROR : SHOW;
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        state_d = ERROR;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end

                SHOW: begin
                    if (press && is_digit) begin
                        clr_d   = 1'b1;
                        shift_d = 1'b1;
                        digit_d = bus.key_value;
                        cnt_d   = 3'd1;
                        state_d = ENTER_A;
                    end else if (press && is_op) begin
                        ldar_d  = 1'b1;
                        clr_d   = 1'b1;
                        op_d    = op_code;
                        cnt_d   = '0;
                        state_d = ENTER_B;
                    end
                end

                ERROR: begin
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        unique case (state_q)
            IDLE:                   bus.disp_sel = 2'd3;
            ENTER_A, ENTER_B, EXEC: bus.disp_sel = 2'd0;
            SHOW:                   bus.disp_sel = 2'd1;
            ERROR:                  bus.disp_sel = 2'd2;
            default:                bus.disp_sel = 2'd3;
        endcase
    end

    assign bus.digit_shift = shift_q;
    assign bus.key_digit   = digit_q;
    assign bus.clr_entry   = clr_q;
    assign bus.load_a      = lda_q;
    assign bus.load_a_res  = ldar_q;
    assign bus.load_b      = ldb_q;
    assign bus.alu_start   = start_q;
    assign bus.op          = op_q;
    assign bus.digit_cnt   = cnt_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: entry flow, digit limit, key hold, operator
// replacement, ALU error/timeout, result chaining, clear and asynchronous reset.
module tb_calc_sequencer;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    calc_sequencer_if bus();

    calc_sequencer #(.MAX_DIGITS(3), .TIMEOUT(255)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [5:0] SH = 6'b100000;
    localparam logic [5:0] CL = 6'b010000;
    localparam logic [5:0] LA = 6'b001000;
    localparam logic [5:0] LR = 6'b000100;
    localparam logic [5:0] LB = 6'b000010;
    localparam logic [5:0] ST = 6'b000001;

    logic [5:0] pv;
    assign pv = {bus.digit_shift, bus.clr_entry, bus.load_a, bus.load_a_res,
                 bus.load_b, bus.alu_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic key_down(input logic [3:0] v);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_value = v;
        @(posedge clk);
        #1;
    endtask

    task automatic key_up();
        @(negedge clk);
        bus.key_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_pulse(input logic err);
        @(negedge clk);
        bus.alu_done = 1'b1;
        bus.alu_err  = err;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.alu_done = 1'b0;
        bus.alu_err  = 1'b0;
    endtask

    initial begin
        int shifts;
        reset         = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_value = 4'h0;
        bus.alu_done  = 1'b0;
        bus.alu_err   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 8'(bus.state), 8'd0);
        chk("rst_op", 8'(bus.op), 8'd0);
        chk("rst_cnt", 8'(bus.digit_cnt), 8'd0);
        chk("rst_digit", 8'(bus.key_digit), 8'd0);
        chk("rst_disp", 8'(bus.disp_sel), 8'd3);
        chk("rst_pulses", 8'(pv), 8'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Main flow 123 A 45 F, then ALU completes
        key_down(4'd1);
        chk("a1_pulse", 8'(pv), 8'(SH));
        chk("a1_digit", 8'(bus.key_digit), 8'd1);
        chk("a1_state", 8'(bus.state), 8'd1);
        chk("a1_cnt", 8'(bus.digit_cnt), 8'd1);
        chk("a1_disp", 8'(bus.disp_sel), 8'd0);
        key_up();
        chk("a1_width", 8'(pv), 8'd0);
        key_down(4'd2);
        chk("a2_pulse", 8'(pv), 8'(SH));
        chk("a2_cnt", 8'(bus.digit_cnt), 8'd2);
        key_up();
        key_down(4'd3);
        chk("a3_digit", 8'(bus.key_digit), 8'd3);
        chk("a3_cnt", 8'(bus.digit_cnt), 8'd3);
        key_up();
        key_down(4'hA);
        chk("opA_pulse", 8'(pv), 8'(LA | CL));
        chk("opA_op", 8'(bus.op), 8'd0);
        chk("opA_state", 8'(bus.state), 8'd2);
        chk("opA_cnt", 8'(bus.digit_cnt), 8'd0);
        key_up();
        key_down(4'd4);
        chk("b4_pulse", 8'(pv), 8'(SH));
        key_up();
        key_down(4'd5);
        chk("b5_cnt", 8'(bus.digit_cnt), 8'd2);
        key_up();
        key_down(4'hF);
        chk("eq_pulse", 8'(pv), 8'(LB | ST));
        chk("eq_state", 8'(bus.state), 8'd3);
        key_up();
        chk("eq_width", 8'(pv), 8'd0);
        alu_pulse(1'b0);
        chk("show_state", 8'(bus.state), 8'd4);
        chk("show_disp", 8'(bus.disp_sel), 8'd1);

        // '=' in SHOW does nothing; then chain with B
        key_down(4'hF);
        chk("show_eq", 8'(pv), 8'd0);
        key_up();
        key_down(4'hB);
        chk("chain_pulse", 8'(pv), 8'(LR | CL));
        chk("chain_op", 8'(bus.op), 8'd1);
        chk("chain_state", 8'(bus.state), 8'd2);
        key_up();
        key_down(4'd6);
        key_up();
        key_down(4'hF);
        key_up();
        alu_pulse(1'b0);
        chk("show2_state", 8'(bus.state), 8'd4);
        key_down(4'd5);
        chk("restart_pulse", 8'(pv), 8'(CL | SH));
        chk("restart_state", 8'(bus.state), 8'd1);
        chk("restart_cnt", 8'(bus.digit_cnt), 8'd1);
        chk("restart_digit", 8'(bus.key_digit), 8'd5);
        key_up();

        // Clear, then digit limit
        key_down(4'hE);
        chk("clr_pulse", 8'(pv), 8'(CL));
        chk("clr_state", 8'(bus.state), 8'd0);
        chk("clr_op", 8'(bus.op), 8'd0);
        key_up();
        for (int i = 0; i < 4; i++) begin
            key_down(4'd9);
            chk("lim_pulse", 8'(pv), (i < 3) ? 8'(SH) : 8'd0);
            key_up();
        end
        chk("lim_cnt", 8'(bus.digit_cnt), 8'd3);

        // Holding key_valid yields one event
        key_down(4'hE);
        key_up();
        shifts = 0;
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_value = 4'd8;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.digit_shift) shifts++;
        end
        chk("hold_shifts", 8'(shifts), 8'd1);
        chk("hold_cnt", 8'(bus.digit_cnt), 8'd1);
        key_up();

        // Operator replacement, '=' with empty B, operator with B present
        key_down(4'hE);
        key_up();
        key_down(4'd7);
        key_up();
        key_down(4'hA);
        key_up();
        key_down(4'hD);
        chk("repl_pulse", 8'(pv), 8'd0);
        chk("repl_op", 8'(bus.op), 8'd3);
        key_up();
        key_down(4'hF);
        chk("eq_empty_pulse", 8'(pv), 8'd0);
        chk("eq_empty_state", 8'(bus.state), 8'd2);
        key_up();
        key_down(4'd2);
        key_up();
        key_down(4'hB);
        chk("op_ignored", 8'(bus.op), 8'd3);
        key_up();
        key_down(4'hF);
        chk("div_start", 8'(pv), 8'(LB | ST));
        chk("div_op", 8'(bus.op), 8'd3);
        key_up();
        key_down(4'd4);
        chk("exec_digit", 8'(pv), 8'd0);
        key_up();
        alu_pulse(1'b1);
        chk("alu_err_state", 8'(bus.state), 8'd5);
        chk("alu_err_disp", 8'(bus.disp_sel), 8'd2);

        // Timeout after 255 cycles in EXEC
        key_down(4'hE);
        key_up();
        key_down(4'd1);
        key_up();
        key_down(4'hC);
        key_up();
        key_down(4'd2);
        key_up();
        key_down(4'hF);
        @(negedge clk);
        bus.key_valid = 1'b0;
        repeat (254) @(posedge clk);
        #1;
        chk("to_before", 8'(bus.state), 8'd3);
        @(posedge clk);
        #1;
        chk("to_state", 8'(bus.state), 8'd5);
        chk("to_disp", 8'(bus.disp_sel), 8'd2);
        key_down(4'd3);
        chk("err_digit_pulse", 8'(pv), 8'd0);
        chk("err_digit_state", 8'(bus.state), 8'd5);
        chk("err_digit_kd", 8'(bus.key_digit), 8'd2);
        key_up();
        key_down(4'hE);
        chk("err_clr_pulse", 8'(pv), 8'(CL));
        chk("err_clr_state", 8'(bus.state), 8'd0);
        chk("err_clr_op", 8'(bus.op), 8'd0);
        key_up();

        // alu_done on the expiry edge wins
        key_down(4'd1);
        key_up();
        key_down(4'hA);
        key_up();
        key_down(4'd1);
        key_up();
        key_down(4'hF);
        @(negedge clk);
        bus.key_valid = 1'b0;
        repeat (254) @(posedge clk);
        @(negedge clk);
        bus.alu_done = 1'b1;
        @(posedge clk);
        #1;
        chk("to_race", 8'(bus.state), 8'd4);
        @(negedge clk);
        bus.alu_done = 1'b0;

        // Clear aborts EXEC; a late alu_done is ignored
        key_down(4'd3);
        key_up();
        key_down(4'hA);
        key_up();
        key_down(4'd3);
        key_up();
        key_down(4'hF);
        key_up();
        key_down(4'hE);
        chk("abort_state", 8'(bus.state), 8'd0);
        key_up();
        alu_pulse(1'b0);
        chk("abort_done", 8'(bus.state), 8'd0);

        // Asynchronous reset while alu_start is high
        key_down(4'd1);
        key_up();
        key_down(4'hA);
        key_up();
        key_down(4'd1);
        key_up();
        key_down(4'hF);
        chk("pre_rst_pulse", 8'(pv), 8'(LB | ST));
        #2;
        reset = 1'b0;
        bus.key_valid = 1'b0;
        #1;
        chk("arst_pulses", 8'(pv), 8'd0);
        chk("arst_state", 8'(bus.state), 8'd0);
        chk("arst_disp", 8'(bus.disp_sel), 8'd3);
        chk("arst_kd", 8'(bus.key_digit), 8'd0);
        chk("arst_cnt", 8'(bus.digit_cnt), 8'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.alu_done = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_done", 8'(bus.state), 8'd0);
        @(negedge clk);
        bus.alu_done = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_done2", 8'(bus.state), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Top-level input sequencer for the calculator. It consumes decoded keypad events (4-bit key code plus valid strobe) and drives the operand shift register and the operand latches. It also starts the arithmetic unit and selects what the display shows. It implements the entry flow A, operator, B, '=', result, including result chaining, digit limiting, clear, and ALU timeout.

Parameters:
MAX_DIGITS, 3, maximum BCD digits accepted per operand (1..4)
TIMEOUT, 255, clock cycles allowed between alu_start and alu_done before ERROR

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
key_valid  input  1  key-event strobe from keypad scanner; level, may stay high several cycles
key_value  input  4  key code: 0-9 digit, A add, B sub, C mul, D div, E clear, F equals
alu_done  input  1  single-cycle completion pulse from arithmetic unit
alu_err  input  1  qualified by alu_done; overflow/divide-by-zero
digit_shift  output  1  one-cycle pulse: shift key_digit into entry shift register
key_digit  output  4  registered digit accompanying digit_shift
clr_entry  output  1  one-cycle pulse: clear entry shift register
load_a  output  1  one-cycle pulse: latch entry as operand A
load_a_res  output  1  one-cycle pulse: latch previous result as operand A
load_b  output  1  one-cycle pulse: latch entry as operand B
alu_start  output  1  one-cycle pulse: start operation
op  output  2  latched operator: 0 add, 1 sub, 2 mul, 3 div
disp_sel  output  2  0 entry, 1 result, 2 error, 3 blank
digit_cnt  output  3  digits entered in current operand
state  output  3  current FSM state encoding

Behaviour:
- Reset (reset=0, async) forces state=IDLE and op=0. It also forces digit_cnt=0, key_digit=0 and disp_sel=3. All pulse outputs are 0. Release is synchronous to the next clk edge.
- Key event definition: a rising edge of key_valid (registered previous value is 0, current is 1). Holding key_valid high produces exactly one event.
- Event timing: an event sampled at edge k causes its pulses and state/op/digit_cnt updates to be visible from edge k, i.e. registered outputs valid for the cycle following edge k. All pulses are exactly 1 cycle wide.
- State encodings: IDLE=0, ENTER_A=1, ENTER_B=2, EXEC=3, SHOW=4, ERROR=5.
- IDLE (disp 3):
  - digit: digit_shift, digit_cnt=1, go to ENTER_A.
  - operator or '=': ignored.
- ENTER_A (disp 0):
  - digit: if digit_cnt<MAX_DIGITS, digit_shift and digit_cnt+1; else ignored with no pulse.
  - operator: load_a and clr_entry in the same cycle, op latched, digit_cnt=0, go to ENTER_B.
  - '=': ignored.
- ENTER_B (disp 0):
  - digit: same rule as ENTER_A.
  - operator with digit_cnt=0: op replaced, no other effect.
  - operator with digit_cnt>0: ignored.
  - '=' with digit_cnt>0: load_b and alu_start in the same cycle, go to EXEC, timeout counter cleared.
  - '=' with digit_cnt=0: ignored.
- EXEC (disp 0):
  - All keys except clear are ignored.
  - alu_done & ~alu_err: go to SHOW.
  - alu_done & alu_err: go to ERROR.
  - Counter reaches TIMEOUT without alu_done: go to ERROR.
  - alu_done on the same edge the counter expires: alu_done wins.
- SHOW (disp 1):
  - digit: clr_entry and digit_shift in the same cycle (the register clears before it shifts), digit_cnt=1, go to ENTER_A.
  - operator: load_a_res and clr_entry, op latched, digit_cnt=0, go to ENTER_B.
  - '=': ignored; no re-execution.
- ERROR (disp 2): only clear exits.
- Clear (E), any state: clr_entry, digit_cnt=0, op=0, go to IDLE. In EXEC this aborts the operation. An alu_done arriving after the abort is ignored, because it is only accepted in EXEC.
- alu_done outside EXEC is always ignored. key_digit updates only on digit events.

Test Plan:
- Reset then press 1,2,3,A,4,5,F; pulse alu_done one cycle later with alu_err=0 -> 3 digit_shift pulses (1,2,3), then load_a+clr_entry with op=0, then 2 digit_shift pulses, then load_b+alu_start with state=3, then state=4 with disp_sel=1.
- MAX_DIGITS=3: press 9,9,9,9 -> exactly 3 digit_shift pulses, digit_cnt stays 3. Hold key_valid high 10 cycles on one digit -> exactly 1 event.
- Enter 7, press A then D, then 2, F -> op=3 at alu_start. Press F in ENTER_B with digit_cnt=0 -> no alu_start.
- '=' then withhold alu_done for 255 cycles -> state=5, disp_sel=2. Press digit -> no change. Press E -> state=0, op=0, clr_entry pulse.
- From SHOW press B -> load_a_res+clr_entry, op=1, state=2. Repeat from SHOW pressing 5 -> clr_entry+digit_shift in the same cycle, state=1, digit_cnt=1.
- Assert reset mid-EXEC and pulse alu_done afterwards -> outputs at reset values immediately (asynchronously), state=0, alu_done causes no transition.
